// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule definitions: FSM state type, round bound and
// the small sigma functions used by the W expansion.
package sha256_pkg;

    localparam int ROUNDS_MAX = 64;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND,
        DRAIN
    } state_t;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_wexp.sv
// Combinational W expansion: W_t = sigma1(W_t-2) + W_t-7 + sigma0(W_t-15) + W_t-16 mod 2^32.
module sha256_wexp
    import sha256_pkg::*;
(
    input  logic [31:0] w_m2,
    input  logic [31:0] w_m7,
    input  logic [31:0] w_m15,
    input  logic [31:0] w_m16,
    output logic [31:0] w_t
);

    always_comb begin
        w_t = sigma1(w_m2) + w_m7 + sigma0(w_m15) + w_m16;
    end

endmodule

// File: rtl/sha256_wsched.sv
// SHA-256 message schedule generator: streams M_0..M_15 through, then expands to W_ROUNDS-1.
// Optional SHA256_WSCHED_TAP_EN adds the wtap port exposing the eight newest window words.
module sha256_wsched
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] m_data,
    input  logic        m_valid,
    output logic        m_ready,
    output logic [31:0] w_data,
    output logic [5:0]  w_idx,
    output logic        w_valid,
    input  logic        w_ready,
    output logic        busy,
    output logic        done
`ifdef SHA256_WSCHED_TAP_EN
    ,
    output logic [31:0] wtap [0:7]
`endif
);

    localparam int TW = $clog2(ROUNDS_MAX + 1);
    localparam logic [TW-1:0] T_LOAD_LAST = TW'(15);
    localparam logic [TW-1:0] T_LAST      = TW'(ROUNDS - 1);

    state_t        state;
    logic [TW-1:0] t;
    logic [31:0]   win [0:16-1];
    logic [31:0]   w_exp;
    logic [31:0]   w_next;
    logic          can_adv;
    logic          produce;

    // win[0] always holds the most recently produced word, i.e. W_t-1
    sha256_wexp u_wexp (
        .w_m2  (win[1]),
        .w_m7  (win[6]),
        .w_m15 (win[14]),
        .w_m16 (win[15]),
        .w_t   (w_exp)
    );

    always_comb begin
        can_adv = !w_valid || w_ready;
        m_ready = (state == LOAD) && can_adv;
        produce = ((state == LOAD) && m_valid && can_adv) ||
                  ((state == EXPAND) && can_adv);
        w_next  = (state == LOAD) ? m_data : w_exp;
        busy    = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            t       <= '0;
            w_valid <= 1'b0;
            done    <= 1'b0;
            w_data  <= '0;
            w_idx   <= '0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else begin
            done <= 1'b0;

            if (produce) begin
                w_data  <= w_next;
                w_idx   <= t[5:0];
                w_valid <= 1'b1;
                win[0]  <= w_next;
                for (int i = 1; i < 16; i++) begin
                    win[i] <= win[i-1];
                end
                t <= t + 1'b1;
            end else if (w_valid && w_ready) begin
                w_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        t     <= '0;
                    end
                end
                LOAD: begin
                    if (produce && (t == T_LOAD_LAST)) begin
                        state <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (produce && (t == T_LAST)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_valid && w_ready) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHA256_WSCHED_TAP_EN
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            wtap[i] = win[i];
        end
    end
`endif

endmodule

// File: doc/sha256_wsched.md
SHA256_WSCHED -- requirements
Module: sha256_wsched

Interface
REQ-001 SHALL have parameter ROUNDS, default 64: number of W words produced per block; legal range 17..64.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  begin a new 512-bit block; sampled only in IDLE.
REQ-005 SHALL have port m_data  input  32  message word M_t, t=0..15, big-endian word order.
REQ-006 SHALL have port m_valid  input  1  m_data valid.
REQ-007 SHALL have port m_ready  output  1  message word accepted when m_valid&&m_ready.
REQ-008 SHALL have port w_data  output  32  schedule word W_t for the compression stage.
REQ-009 SHALL have port w_idx  output  6  round index t of w_data.
REQ-010 SHALL have port w_valid  output  1  w_data/w_idx valid.
REQ-011 SHALL have port w_ready  input  1  W_t consumed when w_valid&&w_ready.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the block's last word is consumed.

Function
REQ-014 SHALL implement states IDLE, LOAD, EXPAND, DRAIN.
REQ-015 IDLE SHALL go to LOAD on start=1 and reset t to 0; start in any other state SHALL be ignored.
REQ-016 A "produce" SHALL load the output register (w_data, w_idx=t, w_valid=1), shift the word into a 16-entry window, and increment t; it occurs only when w_valid=0 or w_ready=1.
REQ-017 In LOAD, m_ready SHALL equal (!w_valid||w_ready); each m_valid&&m_ready SHALL produce W_t=M_t, the word appearing on w_data the following cycle.
REQ-018 After producing t=15, LOAD SHALL go to EXPAND; m_ready SHALL be 0 outside LOAD.
REQ-019 In EXPAND, each produce SHALL compute W_t = sigma1(W_t-2)+W_t-7+sigma0(W_t-15)+W_t-16 mod 2^32, sigma0=ROTR7^ROTR18^SHR3, sigma1=ROTR17^ROTR19^SHR10.
REQ-020 After producing t=ROUNDS-1, the state SHALL become DRAIN; DRAIN SHALL hold until that word is consumed, then pulse done and return to IDLE.
REQ-021 While w_valid=1 and w_ready=0, w_data, w_idx and window SHALL hold unchanged.
REQ-022 A gap in m_valid during LOAD SHALL leave t unchanged and drop w_valid once the pending word is consumed.
REQ-023 With m_valid=1 and w_ready=1 continuously, SHALL sustain one word per cycle: ROUNDS words in ROUNDS consecutive cycles.

Reset
REQ-024 rst SHALL force IDLE, t=0, w_valid=0, m_ready=0, busy=0, done=0, w_data=0, w_idx=0, window=0 on the next edge, including mid-block; rst has priority over start.

Configuration
REQ-025 With SHA256_WSCHED_TAP_EN defined, SHALL add output wtap [0:7] of 32 bits holding the eight newest window words (wtap[0]=newest), for board display.
REQ-026 Without SHA256_WSCHED_TAP_EN, wtap SHALL not exist and function SHALL be identical.

Structure
REQ-027 sha256_pkg SHALL hold the sigma0/sigma1 functions, the state enum typedef and the ROUNDS_MAX=64 constant.
REQ-028 The W expansion adder SHALL be one combinational sub-module, sha256_wexp (inputs W_t-2, W_t-7, W_t-15, W_t-16; output W_t).

Verification
REQ-029 "abc" padded block (M0=0x61626380, M1..M14=0, M15=0x00000018), w_ready=1 -> W16=0x61626380, W17=0x000F0000, 64 words, w_idx 0..63 in order, done one cycle after W63 consumed.
REQ-030 w_ready=0 for 5 cycles while w_idx=20 -> w_data/w_idx constant throughout; W21 appears the cycle after w_ready returns.
REQ-031 m_valid deasserted 3 cycles after M5 -> no w_idx advance; M6 emitted correctly after resume; final words match the gap-free run.
REQ-032 rst asserted at w_idx=30 -> next cycle busy=0, w_valid=0; new start with the "abc" block reproduces REQ-029 results.
REQ-033 start pulsed while busy at w_idx=40 -> ignored; block completes normally with a single done pulse.
REQ-034 Continuous m_valid/w_ready -> start to first w_valid = 2 cycles; 64 w_valid cycles back-to-back.
